sync_debounce: RTL and testbench

Parametrised successor to the team's 2-flop synchronizer, used on keypad row/column sense inputs. Each of N asynchronous inputs passes through a synchronizer of STAGES flops, then a per-channel debounce filter. The filter accepts a new level only after it has been stable for DB_CYCLES consecutive clocks. Outputs are the debounced levels plus one-cycle rise/fall strobes, which the scan FSM consumes directly.

---
 rtl/sync_pkg.sv | 11 +
 rtl/sync_db_chan.sv | 86 ++++++++
 rtl/sync_debounce.sv | 86 ++++++++
 tb/tb_sync_debounce.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and types for the sync_debounce keypad sense front-end.
package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned DEF_DB_CYCLES   = 16;

  typedef logic [7:0] glitch_cnt_t;

  localparam glitch_cnt_t GLITCH_CNT_MAX = 8'hFF;

endpackage : sync_pkg

// File: rtl/sync_db_chan.sv
// One input channel: STAGES-deep synchronizer followed by a stability filter with edge strobes.
// With SYNC_DEBOUNCE_GLITCH_CNT_EN defined, also flags rejected glitches to the parent.
module sync_db_chan
  import sync_pkg::*;
#(
  parameter int unsigned STAGES    = SYNC_MIN_STAGES,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic strobe_c
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic glitch_c
`endif
);

  localparam int unsigned    CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_db_chan: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("sync_db_chan: DB_CYCLES must be >= 1");
  end

  logic [STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              q_q, q_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              s;

  assign sync_d = {sync_q[STAGES-2:0], d};
  assign s      = sync_q[STAGES-1];

  // Count consecutive mismatches; accept the new level on the DB_CYCLES-th one.
  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      q_d    = s;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q        = q_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign strobe_c = rise_d | fall_d;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  // A pending count collapsing back to zero without a q update is a rejected glitch.
  assign glitch_c = (s == q_q) && (cnt_q != '0);
`endif

endmodule : sync_db_chan

// File: rtl/sync_debounce.sv
// N-channel synchronizer + debounce for keypad sense lines, with rise/fall strobes and a change flag.
// Optional SYNC_DEBOUNCE_GLITCH_CNT_EN adds a saturating rejected-glitch counter (glitch_cnt/glitch_clr).
module sync_debounce
  import sync_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned STAGES    = SYNC_MIN_STAGES,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic         glitch_clr,
  output glitch_cnt_t  glitch_cnt
`endif
);

  logic [N-1:0] strobe_c;
  logic         changed_q, changed_d;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [N-1:0] glitch_c;
`endif

  for (genvar i = 0; i < N; i++) begin : g_chan
    sync_db_chan #(
      .STAGES    (STAGES),
      .DB_CYCLES (DB_CYCLES)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .d        (d[i]),
      .q        (q[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .strobe_c (strobe_c[i])
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_c (glitch_c[i])
`endif
    );
  end

  // Built from the channels' next-state strobes so changed lines up with rise/fall.
  assign changed_d = |strobe_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  glitch_cnt_t glitch_cnt_q, glitch_cnt_d;

  // Clear beats increment; simultaneous rejections on several channels count once.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if ((|glitch_c) && (glitch_cnt_q != GLITCH_CNT_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule : sync_debounce

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: two configurations (STAGES=2/DB=4 and STAGES=3/DB=1) checked every cycle
// against a sample-history model, plus directed literal checks; honours SYNC_DEBOUNCE_GLITCH_CNT_EN.
module tb_sync_debounce;

  localparam int unsigned N    = 4;
  localparam int          HMAX = 32768;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] d = '0;
  logic         glitch_clr = 1'b0;

  logic [N-1:0] q_a, rise_a, fall_a, q_b, rise_b, fall_b;
  logic         chg_a, chg_b;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]   gcnt_a, gcnt_b;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sync_debounce #(.N(N), .STAGES(2), .DB_CYCLES(4)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .q          (q_a),
    .rise       (rise_a),
    .fall       (fall_a),
    .changed    (chg_a)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (gcnt_a)
`endif
  );

  sync_debounce #(.N(N), .STAGES(3), .DB_CYCLES(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .q          (q_b),
    .rise       (rise_b),
    .fall       (fall_b),
    .changed    (chg_b)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_clr (1'b0),
    .glitch_cnt (gcnt_b)
`endif
  );

  // Model: history of raw d samples since reset; q flips when the last DB synchronized samples all disagree with it.
  logic [N-1:0] hist [2][HMAX];
  int           hn [2]  = '{0, 0};
  logic [N-1:0] mq [2]  = '{'0, '0};
  logic [N-1:0] mr [2]  = '{'0, '0};
  logic [N-1:0] mf [2]  = '{'0, '0};
  logic         mc [2]  = '{1'b0, 1'b0};
  int           mg [2]  = '{0, 0};

  function automatic logic smp(int m, int idx, int ch);
    if (idx < 0) return 1'b0;
    return hist[m][idx][ch];
  endfunction

  task automatic model_reset(int m);
    hn[m] = 0;
    mq[m] = '0;
    mr[m] = '0;
    mf[m] = '0;
    mc[m] = 1'b0;
    mg[m] = 0;
  endtask

  task automatic model_edge(int m, int st, int db, logic clr);
    int           k;
    logic [N-1:0] nq, r, f;
    logic         gl, all;
    k = hn[m];
    if (k >= HMAX) begin
      $display("FAIL model_hist: history depth %0d required below %0d", k, HMAX);
      $fatal(1);
    end
    hist[m][k] = d;
    hn[m] = k + 1;
    nq = mq[m];
    r = '0;
    f = '0;
    gl = 1'b0;
    for (int ch = 0; ch < int'(N); ch++) begin
      all = 1'b1;
      for (int j = 0; j < db; j++)
        if (smp(m, k - st - j, ch) == mq[m][ch]) all = 1'b0;
      if (all) begin
        nq[ch] = ~mq[m][ch];
        if (nq[ch]) r[ch] = 1'b1;
        else        f[ch] = 1'b1;
      end
      if (smp(m, k - st, ch) == mq[m][ch] && smp(m, k - 1 - st, ch) != mq[m][ch]) gl = 1'b1;
    end
    mq[m] = nq;
    mr[m] = r;
    mf[m] = f;
    mc[m] = |(r | f);
    if (clr) mg[m] = 0;
    else if (gl && mg[m] < 255) mg[m] = mg[m] + 1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, 2, 4, glitch_clr);
      model_edge(1, 3, 1, 1'b0);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("q_a",    32'(q_a),    32'(mq[0]));
    check("rise_a", 32'(rise_a), 32'(mr[0]));
    check("fall_a", 32'(fall_a), 32'(mf[0]));
    check("chg_a",  32'(chg_a),  32'(mc[0]));
    check("q_b",    32'(q_b),    32'(mq[1]));
    check("rise_b", 32'(rise_b), 32'(mr[1]));
    check("fall_b", 32'(fall_b), 32'(mf[1]));
    check("chg_b",  32'(chg_b),  32'(mc[1]));
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("gcnt_a", 32'(gcnt_a), 32'(mg[0]));
    check("gcnt_b", 32'(gcnt_b), 32'(mg[1]));
`endif
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b0;
    d = 4'hF;
    tick(3);
    check("lit_rst_q",    32'(q_a),    32'h0);
    check("lit_rst_rise", 32'(rise_a), 32'h0);
    check("lit_rst_qb",   32'(q_b),    32'h0);
    #1 reset = 1'b1;
    tick(3);
    check("lit_rel_qb3",  32'(q_b),    32'h0);
    tick(1);
    check("lit_rel_qb4",  32'(q_b),    32'hF);
    check("lit_rel_rb4",  32'(rise_b), 32'hF);
    tick(1);
    check("lit_rel_q5",   32'(q_a),    32'h0);
    tick(1);
    check("lit_rel_q6",   32'(q_a),    32'hF);
    check("lit_rel_r6",   32'(rise_a), 32'hF);
    check("lit_rel_c6",   32'(chg_a),  32'h1);
    tick(1);
    check("lit_rel_r7",   32'(rise_a), 32'h0);
    check("lit_rel_c7",   32'(chg_a),  32'h0);

    // clean step on channel 0, up then down
    #1 d = 4'h0;
    tick(10);
    #1 d = 4'h1;
    tick(5);
    check("lit_step_q5",  32'(q_a),    32'h0);
    tick(1);
    check("lit_step_q6",  32'(q_a),    32'h1);
    check("lit_step_r6",  32'(rise_a), 32'h1);
    tick(1);
    check("lit_step_r7",  32'(rise_a), 32'h0);
    #1 d = 4'h0;
    tick(5);
    check("lit_fall_f5",  32'(fall_a), 32'h0);
    tick(1);
    check("lit_fall_f6",  32'(fall_a), 32'h1);
    check("lit_fall_q6",  32'(q_a),    32'h0);

    // 3-cycle glitch on channel 1
    #1 glitch_clr = 1'b1;
    tick(1);
    #1 glitch_clr = 1'b0;
    d = 4'h2;
    tick(3);
    #1 d = 4'h0;
    tick(8);
    check("lit_glitch_q", 32'(q_a), 32'h0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("lit_glitch_cnt1", 32'(gcnt_a), 32'h1);
    repeat (300) begin
      #1 d = 4'h2;
      tick(3);
      #1 d = 4'h0;
      tick(5);
    end
    tick(3);
    check("lit_glitch_sat", 32'(gcnt_a), 32'hFF);
    #1 glitch_clr = 1'b1;
    tick(1);
    check("lit_glitch_clr", 32'(gcnt_a), 32'h0);
    #1 glitch_clr = 1'b0;
`endif

    // simultaneous rise on channels 0 and 2
    #1 d = 4'h5;
    tick(5);
    check("lit_sim_q5",   32'(q_a),    32'h0);
    tick(1);
    check("lit_sim_q6",   32'(q_a),    32'h5);
    check("lit_sim_r6",   32'(rise_a), 32'h5);
    check("lit_sim_f6",   32'(fall_a), 32'h0);
    check("lit_sim_c6",   32'(chg_a),  32'h1);

    // reset mid-count discards the pending change
    #1 d = 4'h0;
    tick(10);
    #1 d = 4'h4;
    tick(4);
    #1 reset = 1'b0;
    tick(1);
    check("lit_mid_q",    32'(q_a),    32'h0);
    check("lit_mid_r",    32'(rise_a), 32'h0);
    tick(1);
    #1 reset = 1'b1;
    tick(5);
    check("lit_mid_q5",   32'(q_a),    32'h0);
    tick(1);
    check("lit_mid_q6",   32'(q_a),    32'h4);
    check("lit_mid_r6",   32'(rise_a), 32'h4);

    // pure synchronizer config: step on channel 3
    #1 d = 4'hC;
    tick(3);
    check("lit_db1_q3",   32'(q_b),    32'h4);
    tick(1);
    check("lit_db1_q4",   32'(q_b),    32'hC);
    check("lit_db1_r4",   32'(rise_b), 32'h8);
    tick(1);
    check("lit_db1_r5",   32'(rise_b), 32'h0);

    // randomized levels, hold lengths, clears and occasional resets
    for (int it = 0; it < 500; it++) begin
      #1 d = 4'($urandom);
      glitch_clr = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 30) != 0);
      tick($urandom_range(1, 9));
    end
    #1 reset = 1'b1;
    glitch_clr = 1'b0;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_sync_debounce
